census_window_ctrl: RTL and testbench
=====================================

CENSUS_WINDOW_CTRL -- requirements
Module: census_window_ctrl

Interface
REQ-001 The block SHALL have parameter BOX_WIDTH, default 3, the census window side (odd, >=3).
REQ-002 The block SHALL have parameter IMG_WIDTH, default 640, the pixels per row.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 480, the rows per frame.
REQ-004 The block SHALL have parameter CNT_W, default 12, the coordinate counter width.
REQ-005 The block SHALL have port clk  input  1  clock, and all logic SHALL be rising-edge.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have port pix_valid  input  1  a column of BOX_WIDTH pixels is offered by the line buffer.
REQ-008 The block SHALL have port pix_sof  input  1  start of frame, qualified by pix_valid.
REQ-009 The block SHALL have port pix_ready  output  1  the column is accepted when pix_valid&pix_ready.
REQ-010 The block SHALL have port he  output  1  shift enable to the census register array; one shift per high cycle.
REQ-011 The block SHALL have port ham_valid  output  1  the census string at the array output is a valid full window.
REQ-012 The block SHALL have port ham_ready  input  1  downstream accepts the census string.
REQ-013 The block SHALL have ports ham_x, ham_y  output  CNT_W each  window centre coordinates for the current ham_valid.
REQ-014 The block SHALL have port frame_done  output  1  one-cycle pulse at end of frame.
REQ-015 The block SHALL have port sof_err  output  1  one-cycle pulse on an unexpected pix_sof.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-017 In IDLE: pix_ready=1; columns without pix_sof SHALL be accepted and discarded (he=0); pix_valid&pix_sof SHALL be accepted with he=1, set x=0,y=0 as the coordinate of that column, and go to RUN.
REQ-018 The stall condition SHALL be stall = ham_valid & ~ham_ready; in RUN pix_ready SHALL equal ~stall, and he SHALL equal pix_valid & ~stall.
REQ-019 Each accepted column in RUN SHALL advance x; at x=IMG_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-020 Acceptance of column (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL move the FSM to DRAIN; pix_ready SHALL be 0 in DRAIN.
REQ-021 A two-stage tag pipeline {valid,x,y} SHALL advance only in cycles with he=1, matching the array's two-register latency.
REQ-022 A stage-0 tag SHALL be valid iff x>=BOX_WIDTH-1 and y>=BOX_WIDTH-1 (the window does not straddle a row wrap or the frame top).
REQ-023 ham_valid SHALL be the stage-2 tag valid bit; ham_x SHALL equal tag x-(BOX_WIDTH>>1) and ham_y SHALL equal tag y-(BOX_WIDTH>>1).
REQ-024 The stage-2 output SHALL hold stable while stall is active.
REQ-025 In DRAIN, he SHALL pulse high on exactly 2 non-stalled cycles with stage-0 tag invalid; after the second drain shift, frame_done SHALL pulse high for one cycle and the FSM SHALL return to IDLE.
REQ-026 In IDLE, any ham_valid left from drain SHALL be held until accepted and SHALL block the next he shift.
REQ-027 pix_sof accepted in RUN SHALL pulse sof_err, flush both tags to invalid, and restart the frame at x=0,y=0 with that column.
REQ-028 pix_sof is not expected in DRAIN (pix_ready=0 there), and any pix_sof presented in DRAIN SHALL be ignored.
REQ-029 Coordinate arithmetic SHALL be unsigned CNT_W bits; the subtraction in REQ-023 SHALL never underflow because of the guard in REQ-022.

Reset
REQ-030 While reset is high, the FSM SHALL be IDLE and the tags, x, y, he, ham_valid, ham_x, ham_y, frame_done and sof_err SHALL all be 0; pix_ready SHALL be 1.
REQ-031 Assertion of reset mid-frame SHALL abandon the frame immediately without a frame_done pulse.

Verification (BOX_WIDTH=3, IMG_WIDTH=8, IMG_HEIGHT=4)
REQ-032 With continuous pix_valid, sof on the first column and ham_ready=1 -> exactly 12 ham_valid beats with (ham_x,ham_y) from (1,1) through (6,2) in raster order, and frame_done 2 shifts after the last input.
REQ-033 With ham_ready held low for 5 cycles at the first ham_valid -> pix_ready=0 and he=0 throughout the stall, ham_x=1/ham_y=1 held stable, and no beat lost or duplicated.
REQ-034 With 10 columns sent without sof and then a column with sof -> the first 10 are discarded with he=0, and the output matches REQ-032 when the frame is started by the sof column.
REQ-035 With sof sent again at input column 13 -> a sof_err pulse, no ham_valid for windows of the old frame not yet output, and the frame restarts at (0,0).
REQ-036 With reset asserted during RUN -> all outputs return to their reset values asynchronously, there is no frame_done, and the next sof frame is correct.
REQ-037 With pix_valid toggling 1/0 every cycle -> the same 12 beats as REQ-032, and he is high only on accepted cycles.

Source files
------------

// File: rtl/census_window_ctrl.sv
// census_window_ctrl
//
// Controls a census-transform register array that is fed one column of
// BOX_WIDTH pixels per accepted beat from a line buffer. It decides when the
// array shifts (he), tracks the raster coordinate of every column entering the
// array and reports, two shifts later, whether the array output holds a full
// window and where that window is centred.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   pix_valid   line buffer offers a column
//   pix_sof     offered column is the first of a frame (qualified by pix_valid)
//   pix_ready   column accepted when pix_valid & pix_ready
//   he          shift enable for the census register array (one shift per cycle high)
//   ham_valid   census string at the array output is a complete window
//   ham_ready   downstream accepts the census string
//   ham_x/ham_y centre coordinate of the window presented with ham_valid
//   frame_done  one-cycle pulse once the last window of a frame has been shifted out
//   sof_err     one-cycle pulse when a start of frame arrives in mid-frame
module census_window_ctrl #(
    parameter int BOX_WIDTH  = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic             he,
    output logic             ham_valid,
    input  logic             ham_ready,
    output logic [CNT_W-1:0] ham_x,
    output logic [CNT_W-1:0] ham_y,
    output logic             frame_done,
    output logic             sof_err
);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(BOX_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(BOX_WIDTH / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Raster position of the next column to be accepted.
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    // Low while waiting for the first drain shift, high for the second.
    logic             drain_phase;

    logic             stall;
    logic             shift;
    logic             start;
    logic             restart;
    logic             advance;
    logic             drain_last;

    logic             vld_p0;
    logic [CNT_W-1:0] x_p0;
    logic [CNT_W-1:0] y_p0;
    logic             vld_p1;
    logic [CNT_W-1:0] x_p1;
    logic [CNT_W-1:0] y_p1;
    logic             vld_p2;
    logic [CNT_W-1:0] x_p2;
    logic [CNT_W-1:0] y_p2;
    logic             take_p1;

    // Converts the bottom-right corner of a window into its centre. Only
    // applied to tags that passed the full-window guard, so it never wraps.
    function automatic logic [CNT_W-1:0] to_centre(input logic [CNT_W-1:0] corner);
        return corner - HALF;
    endfunction

    assign stall = ham_valid & ~ham_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        shift      = 1'b0;
        start      = 1'b0;
        restart    = 1'b0;
        advance    = 1'b0;
        drain_last = 1'b0;
        x_p0       = x;
        y_p0       = y;
        case (state)
            IDLE: begin
                // Stray columns are taken and dropped; an unconsumed window
                // still sitting at the array output holds off the next shift.
                pix_ready = ~stall;
                if (pix_valid && !stall && pix_sof) begin
                    shift      = 1'b1;
                    start      = 1'b1;
                    x_p0       = '0;
                    y_p0       = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                pix_ready = ~stall;
                if (pix_valid && !stall) begin
                    shift = 1'b1;
                    if (pix_sof) begin
                        // Frame restarts with this column as (0,0).
                        start   = 1'b1;
                        restart = 1'b1;
                        x_p0    = '0;
                        y_p0    = '0;
                    end else begin
                        advance = 1'b1;
                        if (x == X_LAST && y == Y_LAST) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Two empty shifts push the last column's tag out to stage 2.
                shift = ~stall;
                if (!stall && drain_phase) begin
                    drain_last = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A window is complete only when its bottom-right corner is far enough
    // from the left edge and the frame top; drain shifts carry no column.
    assign vld_p0 = (state != DRAIN) && (x_p0 >= WIN_LAST) && (y_p0 >= WIN_LAST);

    assign he = shift & ~reset;

    // Coordinate counters and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            drain_phase <= 1'b0;
            frame_done  <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            frame_done <= drain_last;
            sof_err    <= restart;
            if (start) begin
                x <= CNT_W'(1);
                y <= '0;
            end else if (advance) begin
                // The last column wraps both counters, leaving (0,0) for the
                // next frame.
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (state == DRAIN && shift) begin
                drain_phase <= ~drain_phase;
            end
        end
    end

    // A mid-frame restart discards every tag of the old frame still in flight.
    assign take_p1 = vld_p1 & ~restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            vld_p2 <= 1'b0;
            x_p2   <= '0;
            y_p2   <= '0;
        end else if (shift) begin
            // ---- stage 0 -> stage 1 ----
            vld_p1 <= vld_p0;
            x_p1   <= x_p0;
            y_p1   <= y_p0;
            // ---- stage 1 -> stage 2 ----
            vld_p2 <= take_p1;
            x_p2   <= take_p1 ? to_centre(x_p1) : '0;
            y_p2   <= take_p1 ? to_centre(y_p1) : '0;
        end else if (ham_valid && ham_ready) begin
            // Consumed without a shift behind it: the array output is now a
            // duplicate of a delivered window.
            vld_p2 <= 1'b0;
        end
    end

    assign ham_valid = vld_p2;
    assign ham_x     = x_p2;
    assign ham_y     = y_p2;

endmodule

// File: tb/tb_census_window_ctrl.sv
module tb_census_window_ctrl;

    localparam int BW = 3;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_ready;
    logic          he;
    logic          ham_valid;
    logic          ham_ready;
    logic [CW-1:0] ham_x;
    logic [CW-1:0] ham_y;
    logic          frame_done;
    logic          sof_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: raster position of the next in-frame column and the
    // queue of window centres that the frame still owes downstream.
    int exp_x[$];
    int exp_y[$];
    int mx;
    int my;
    bit m_run;
    int exp_total;

    census_window_ctrl #(
        .BOX_WIDTH (BW),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .he        (he),
        .ham_valid (ham_valid),
        .ham_ready (ham_ready),
        .ham_x     (ham_x),
        .ham_y     (ham_y),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input bit sof);
        if (sof) begin
            if (m_run) begin
                exp_total -= exp_x.size();
                exp_x.delete();
                exp_y.delete();
            end
            mx    = 0;
            my    = 0;
            m_run = 1'b1;
        end
        if (!m_run) return;
        if (mx >= BW - 1 && my >= BW - 1) begin
            exp_x.push_back(mx - BW / 2);
            exp_y.push_back(my - BW / 2);
            exp_total++;
        end
        mx++;
        if (mx == IW) begin
            mx = 0;
            my++;
            if (my == IH) m_run = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_ham_valid"}, ham_valid, 1'b0);
        check1({tag, "_he"}, he, 1'b0);
        check1({tag, "_pix_ready"}, pix_ready, 1'b1);
        check1({tag, "_frame_done"}, frame_done, 1'b0);
        check1({tag, "_sof_err"}, sof_err, 1'b0);
        check({tag, "_ham_x"}, 32'(ham_x), 0);
        check({tag, "_ham_y"}, 32'(ham_y), 0);
    endtask

    task automatic mid_reset();
        #2;
        reset     = 1'b1;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_x.delete();
        exp_y.delete();
        m_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        reset     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check1("no_frame_done_after_reset", frame_done, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    // pv_mode: 0 continuous, 1 alternate cycles, 2 random
    // hr_mode: 0 always ready, 1 random, 2 five-cycle stall at first window
    task automatic run_frame(input int pv_mode, input int hr_mode, input int junk,
                             input int restart_at, input int abort_at);
        int            col          = 0;
        int            cyc          = 0;
        int            stall_left   = 0;
        bit            stalled_once = 1'b0;
        int            fd           = 0;
        int            se           = 0;
        int            beats        = 0;
        int            he_after     = 0;
        bit            done_in      = 1'b0;
        bit            restarted    = 1'b0;
        bit            prev_stall   = 1'b0;
        bit            aborted      = 1'b0;
        bit            was_run;
        logic          stall;
        logic [CW-1:0] hold_x = '0;
        logic [CW-1:0] hold_y = '0;
        exp_total = 0;
        while (fd == 0 && cyc < 3000) begin
            if (abort_at > 0 && cyc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (junk > 0) begin
                pix_valid = 1'b1;
                pix_sof   = 1'b0;
            end else if (col < IW * IH) begin
                case (pv_mode)
                    0:       pix_valid = 1'b1;
                    1:       pix_valid = (cyc % 2 == 0);
                    default: pix_valid = ($urandom_range(0, 3) != 0);
                endcase
                pix_sof = pix_valid & ((col == 0) || (col == restart_at && !restarted));
            end else begin
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
            end
            if (hr_mode == 2 && !stalled_once && ham_valid) begin
                stalled_once = 1'b1;
                stall_left   = 5;
            end
            if (hr_mode == 1) begin
                ham_ready = ($urandom_range(0, 2) != 0);
            end else if (stall_left > 0) begin
                ham_ready = 1'b0;
                stall_left--;
            end else begin
                ham_ready = 1'b1;
            end

            @(negedge clk);
            stall = ham_valid & ~ham_ready;
            if (stall) begin
                check1("stall_pix_ready", pix_ready, 1'b0);
                check1("stall_he", he, 1'b0);
            end
            if (hr_mode == 2 && stall) begin
                check("stall_ham_x", 32'(ham_x), 1);
                check("stall_ham_y", 32'(ham_y), 1);
            end
            if (prev_stall) begin
                check1("hold_ham_valid", ham_valid, 1'b1);
                check("hold_ham_x", 32'(ham_x), 32'(hold_x));
                check("hold_ham_y", 32'(ham_y), 32'(hold_y));
            end
            if (pix_valid) begin
                check1("pix_ready", pix_ready, ~stall);
                check1("he_on_accept", he, pix_ready & (m_run | pix_sof));
            end
            if (done_in && he) he_after++;
            if (ham_valid && ham_ready) begin
                beats++;
                if (exp_x.size() == 0) begin
                    check1("extra_beat", ham_valid, 1'b0);
                end else begin
                    check("ham_x", 32'(ham_x), exp_x.pop_front());
                    check("ham_y", 32'(ham_y), exp_y.pop_front());
                end
            end
            if (pix_valid && pix_ready) begin
                if (junk > 0) begin
                    junk--;
                end else if (pix_sof) begin
                    if (col != 0) restarted = 1'b1;
                    col = 1;
                end else begin
                    col++;
                end
                was_run = m_run;
                model_accept(pix_sof);
                if (was_run && !m_run) done_in = 1'b1;
            end
            if (frame_done) begin
                check1("frame_done_early", done_in, 1'b1);
                fd++;
            end
            if (sof_err) se++;
            prev_stall = stall;
            hold_x     = ham_x;
            hold_y     = ham_y;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (aborted) begin
            mid_reset();
        end else begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            ham_ready = 1'b1;
            check("frame_done_count", fd, 1);
            check("beat_count", beats, exp_total);
            if (restart_at < 0 || restart_at == 13) check("beat_count_12", beats, 12);
            check("pending_beats", exp_x.size(), 0);
            check("drain_shifts", he_after, 2);
            check("sof_err_count", se, (restart_at >= 0) ? 1 : 0);
            @(negedge clk);
            check1("frame_done_width", frame_done, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        ham_ready = 1'b1;
        m_run     = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk);
        #1;

        run_frame(0, 0, 0, -1, 0);   // continuous frame
        run_frame(0, 2, 0, -1, 0);   // downstream stall at first window
        run_frame(0, 0, 10, -1, 0);  // stray columns before start of frame
        run_frame(0, 0, 0, 13, 0);   // start of frame repeated mid-frame
        run_frame(0, 0, 0, -1, 22);  // reset in mid-frame
        run_frame(0, 0, 0, -1, 0);   // clean frame after that reset
        run_frame(1, 0, 0, -1, 0);   // input valid on alternate cycles
        run_frame(2, 1, 3, -1, 0);   // random valid/ready
        run_frame(2, 1, 0, $urandom_range(5, 28), 0);
        run_frame(2, 1, 5, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
